// File: rtl/schb_params.sv
// Shared constants and FSM state encoding for the Scabbard
// 64-coefficient product reduction stage.
package schb_params;

   localparam int N      = 64;
   localparam int ADDR_W = 7;
   localparam int DATA_W = 16;
   localparam int Q      = 13;
   localparam int IDX_W  = $clog2(N);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RD_LO = 2'd1,
      RD_HI = 2'd2,
      DRAIN = 2'd3
   } state_t;

endpackage

// File: rtl/poly_coef_round.sv
// Negacyclic fold of one coefficient pair: out = round((lo - hi) mod 2^Q).
// Ports: lo, hi (Q-bit operands) -> out (Q-SHIFT bit rounded result).
module poly_coef_round #(
   parameter int Q     = 13,
   parameter int SHIFT = 0
) (
   input  logic [Q-1:0]       lo,
   input  logic [Q-1:0]       hi,
   output logic [Q-SHIFT-1:0] out
);

   logic [Q-1:0] r;

   assign r = lo - hi;

   generate
      if (SHIFT == 0) begin : g_plain
         assign out = r;
      end else begin : g_round
         logic [Q-1:0] t;
         // Half-LSB bias wraps mod 2^Q before the shift.
         assign t   = r + Q'(1 << (SHIFT - 1));
         assign out = (Q-SHIFT)'(t >> SHIFT);
      end
   endgenerate

endmodule

// File: rtl/poly_reduce_schb_64.sv
// Sweeps the 128-word product memory after multiply, folds c[i]-c[i+64]
// and streams reduced coefficients out over a valid/ready port.
// Ports: clk/resetn; start; mul_addr/mul_rdata/mul_clres memory-op port;
// busy; out_data/out_index/out_last/out_valid/out_ready stream; done pulse.
module poly_reduce_schb_64
   import schb_params::*;
#(
   parameter int SHIFT       = 0,
   parameter bit CLEAR_AFTER = 1'b1
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               start,
   output logic [ADDR_W-1:0]  mul_addr,
   input  logic [DATA_W-1:0]  mul_rdata,
   output logic               mul_clres,
   output logic               busy,
   output logic [Q-SHIFT-1:0] out_data,
   output logic [IDX_W-1:0]   out_index,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               out_last,
   output logic               done
);

   state_t             state;
   state_t             state_nxt;
   logic [IDX_W-1:0]   idx;
   logic [Q-1:0]       lo;
   logic [Q-SHIFT-1:0] coef;
   logic               slot_free;
   logic               accept;
   logic               advance;
   logic               idx_last;
   logic               unused_hi_bits;

   assign slot_free = !out_valid || out_ready;
   assign accept    = out_valid && out_ready;
   assign advance   = (state == RD_HI) && slot_free;
   assign idx_last  = (idx == IDX_W'(N - 1));
   assign busy      = (state != IDLE);

   // Only the low Q bits of a product word carry the coefficient.
   assign unused_hi_bits = ^mul_rdata[DATA_W-1:Q];

   poly_coef_round #(
      .Q     (Q),
      .SHIFT (SHIFT)
   ) u_round (
      .lo  (lo),
      .hi  (mul_rdata[Q-1:0]),
      .out (coef)
   );

   always_comb begin
      state_nxt = state;
      mul_addr  = '0;
      mul_clres = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) state_nxt = RD_LO;
         end
         RD_LO: begin
            mul_addr  = ADDR_W'(idx);
            mul_clres = CLEAR_AFTER;
            state_nxt = RD_HI;
         end
         RD_HI: begin
            mul_addr = ADDR_W'(idx) + ADDR_W'(N);
            // The high word is cleared only in the cycle it is consumed.
            if (slot_free) begin
               mul_clres = CLEAR_AFTER;
               state_nxt = idx_last ? DRAIN : RD_LO;
            end
         end
         DRAIN: begin
            if (accept && out_last) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= IDLE;
         idx       <= '0;
         lo        <= '0;
         out_data  <= '0;
         out_index <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         done      <= 1'b0;
      end else begin
         state <= state_nxt;
         done  <= 1'b0;
         case (state)
            IDLE:    if (start) idx <= '0;
            RD_LO:   lo <= mul_rdata[Q-1:0];
            RD_HI:   if (slot_free) idx <= idx + 1'b1;
            DRAIN:   if (accept && out_last) done <= 1'b1;
            default: ;
         endcase
         if (advance) begin
            out_valid <= 1'b1;
            out_data  <= coef;
            out_index <= idx;
            out_last  <= idx_last;
         end else if (accept) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_poly_reduce_schb_64.sv
// Scoreboard bench for poly_reduce_schb_64: a SHIFT=0/clearing instance
// and a SHIFT=3/non-clearing instance, each with its own memory model.
module tb_poly_reduce_schb_64;
   import schb_params::*;

   typedef struct packed {
      logic [12:0] d;
      logic [5:0]  idx;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        resetn;
   logic        a_start, a_clres, a_busy, a_valid, a_ready, a_last, a_done;
   logic [6:0]  a_addr;
   logic [15:0] a_rdata;
   logic [12:0] a_data;
   logic [5:0]  a_index;
   logic        b_start, b_clres, b_busy, b_valid, b_ready, b_last, b_done;
   logic [6:0]  b_addr;
   logic [15:0] b_rdata;
   logic [9:0]  b_data;
   logic [5:0]  b_index;

   logic [15:0] mem_a [128];
   logic [15:0] mem_b [128];
   logic [15:0] save_b [128];
   int          clr_a [128];
   int          clr_b [128];
   int          acc_cyc [64];

   exp_t q_a[$];
   exp_t q_b[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   acc_a = 0;
   int   acc_b = 0;

   poly_reduce_schb_64 #(.SHIFT(0), .CLEAR_AFTER(1'b1)) dut (
      .clk(clk), .resetn(resetn), .start(a_start),
      .mul_addr(a_addr), .mul_rdata(a_rdata), .mul_clres(a_clres),
      .busy(a_busy), .out_data(a_data), .out_index(a_index),
      .out_valid(a_valid), .out_ready(a_ready), .out_last(a_last),
      .done(a_done)
   );

   poly_reduce_schb_64 #(.SHIFT(3), .CLEAR_AFTER(1'b0)) dut_s3 (
      .clk(clk), .resetn(resetn), .start(b_start),
      .mul_addr(b_addr), .mul_rdata(b_rdata), .mul_clres(b_clres),
      .busy(b_busy), .out_data(b_data), .out_index(b_index),
      .out_valid(b_valid), .out_ready(b_ready), .out_last(b_last),
      .done(b_done)
   );

   assign a_rdata = mem_a[a_addr];
   assign b_rdata = mem_b[b_addr];

   always @(posedge clk) begin
      if (a_clres) begin
         mem_a[a_addr] <= '0;
         clr_a[a_addr] <= clr_a[a_addr] + 1;
      end
      if (b_clres) begin
         mem_b[b_addr] <= '0;
         clr_b[b_addr] <= clr_b[b_addr] + 1;
      end
   end

   always @(negedge clk) begin : mon_a
      exp_t e;
      if (resetn && a_valid && a_ready) begin
         vectors++;
         if (q_a.size() == 0) begin
            miscompares++;
            $display("FAIL a_extra: got idx=%0d data=%0d, required no output",
                     a_index, a_data);
         end else begin
            e = q_a.pop_front();
            if (a_data !== e.d || a_index !== e.idx ||
                a_last !== (e.idx == 6'd63)) begin
               miscompares++;
               $display("FAIL a_coef: got idx=%0d data=%0d last=%0b, required idx=%0d data=%0d",
                        a_index, a_data, a_last, e.idx, e.d);
            end
         end
         acc_cyc[a_index] = cyc;
         acc_a++;
      end
   end

   always @(negedge clk) begin : mon_b
      exp_t e;
      if (resetn && b_valid && b_ready) begin
         vectors++;
         if (q_b.size() == 0) begin
            miscompares++;
            $display("FAIL b_extra: got idx=%0d data=%0d, required no output",
                     b_index, b_data);
         end else begin
            e = q_b.pop_front();
            if ({3'b000, b_data} !== e.d || b_index !== e.idx ||
                b_last !== (e.idx == 6'd63)) begin
               miscompares++;
               $display("FAIL b_coef: got idx=%0d data=%0d last=%0b, required idx=%0d data=%0d",
                        b_index, b_data, b_last, e.idx, e.d);
            end
         end
         acc_b++;
      end
   end

   task automatic fill_a(input bit zero_hi);
      logic [15:0] lo, hi;
      exp_t e;
      q_a.delete();
      acc_a = 0;
      for (int i = 0; i < 64; i++) begin
         lo = zero_hi ? 16'(i + 1) : 16'($urandom);
         hi = zero_hi ? 16'd0 : 16'($urandom);
         if (!zero_hi && i == 0) begin lo = 16'd5; hi = 16'd7; end
         if (!zero_hi && i == 1) begin lo = 16'hFFFF; hi = 16'd0; end
         mem_a[i]      <= lo;
         mem_a[i + 64] <= hi;
         clr_a[i]      <= 0;
         clr_a[i + 64] <= 0;
         e.d   = lo[12:0] - hi[12:0];
         e.idx = 6'(i);
         q_a.push_back(e);
      end
   endtask

   task automatic kick_a(output int k);
      @(negedge clk);
      a_start = 1'b1;
      @(posedge clk);
      #1;
      a_start = 1'b0;
      k = cyc;
   endtask

   task automatic wait_done_a(output int dc, output bit ok);
      ok = 1'b0;
      dc = 0;
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         if (a_done) begin
            dc = cyc;
            ok = 1'b1;
            return;
         end
      end
   endtask

   task automatic test_reset;
      resetn  = 1'b0;
      a_start = 1'b0;
      b_start = 1'b0;
      a_ready = 1'b1;
      b_ready = 1'b1;
      for (int i = 0; i < 128; i++) begin
         mem_a[i] <= '0; mem_b[i] <= '0;
         clr_a[i] <= 0;  clr_b[i] <= 0;
      end
      repeat (3) @(negedge clk);
      vectors++;
      if ({a_addr, a_clres, a_busy, a_valid, a_data, a_index, a_last, a_done} !== '0) begin
         miscompares++;
         $display("FAIL reset_a: outputs=%h, required 0",
                  {a_addr, a_clres, a_busy, a_valid, a_data, a_index, a_last, a_done});
      end
      vectors++;
      if ({b_addr, b_clres, b_busy, b_valid, b_data, b_index, b_last, b_done} !== '0) begin
         miscompares++;
         $display("FAIL reset_b: outputs=%h, required 0",
                  {b_addr, b_clres, b_busy, b_valid, b_data, b_index, b_last, b_done});
      end
      resetn = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_timing;
      int k, dc, bad;
      bit ok;
      fill_a(1'b1);
      a_ready = 1'b1;
      kick_a(k);
      @(negedge clk);
      vectors++;
      if (a_addr !== 7'd0 || a_busy !== 1'b1) begin
         miscompares++;
         $display("FAIL addr_lo: got addr=%0d busy=%0b, required 0/1", a_addr, a_busy);
      end
      @(negedge clk);
      vectors++;
      if (a_addr !== 7'd64) begin
         miscompares++;
         $display("FAIL addr_hi: got %0d, required 64", a_addr);
      end
      wait_done_a(dc, ok);
      vectors++;
      if (!ok || dc != k + 129) begin
         miscompares++;
         $display("FAIL done_cycle: got %0d (seen=%0b), required %0d", dc, ok, k + 129);
      end
      bad = 0;
      for (int j = 0; j < 64; j++) if (acc_cyc[j] != k + 2 + 2 * j) bad++;
      vectors++;
      if (bad != 0) begin
         miscompares++;
         $display("FAIL coef_timing: %0d coefficients off-cycle, required 0", bad);
      end
      vectors++;
      if (acc_a != 64 || q_a.size() != 0) begin
         miscompares++;
         $display("FAIL count: got %0d accepted (%0d pending), required 64/0",
                  acc_a, q_a.size());
      end
      @(negedge clk);
      vectors++;
      if (a_done !== 1'b0 || a_busy !== 1'b0) begin
         miscompares++;
         $display("FAIL done_pulse: got done=%0b busy=%0b, required 0/0", a_done, a_busy);
      end
      bad = 0;
      for (int i = 0; i < 128; i++) if (mem_a[i] != 0 || clr_a[i] != 1) bad++;
      vectors++;
      if (bad != 0) begin
         miscompares++;
         $display("FAIL clear_once: %0d words wrong, required 0", bad);
      end
   endtask

   task automatic test_arith_random_ready;
      int k;
      bit seen;
      fill_a(1'b0);
      kick_a(k);
      seen = 1'b0;
      for (int n = 0; n < 1000 && !seen; n++) begin
         @(posedge clk);
         #1;
         a_ready = 1'($urandom_range(0, 1));
         if (a_done) seen = 1'b1;
      end
      a_ready = 1'b1;
      vectors++;
      if (!seen || acc_a != 64 || q_a.size() != 0) begin
         miscompares++;
         $display("FAIL arith_stream: got done=%0b accepted=%0d pending=%0d, required 1/64/0",
                  seen, acc_a, q_a.size());
      end
      @(negedge clk);
   endtask

   task automatic test_backpressure;
      int k, bad_hold, bad_addr;
      bit found, seen;
      exp_t e5;
      fill_a(1'b0);
      e5 = q_a[5];
      a_ready = 1'b1;
      kick_a(k);
      found = 1'b0;
      for (int n = 0; n < 200 && !found; n++) begin
         @(posedge clk);
         #1;
         if (a_valid && a_index == 6'd5) found = 1'b1;
      end
      a_ready = 1'b0;
      bad_hold = 0;
      bad_addr = 0;
      for (int s = 0; s < 10; s++) begin
         @(negedge clk);
         if (a_valid !== 1'b1 || a_data !== e5.d || a_index !== 6'd5) bad_hold++;
         if (s >= 1 && (a_addr !== 7'd70 || a_clres !== 1'b0)) bad_addr++;
      end
      vectors++;
      if (!found || bad_hold != 0) begin
         miscompares++;
         $display("FAIL stall_hold: found=%0b, %0d unstable cycles, data=%0d required %0d",
                  found, bad_hold, a_data, e5.d);
      end
      vectors++;
      if (bad_addr != 0) begin
         miscompares++;
         $display("FAIL stall_addr: %0d cycles addr=%0d clres=%0b, required 70/0",
                  bad_addr, a_addr, a_clres);
      end
      @(posedge clk);
      #1;
      a_ready = 1'b1;
      seen = 1'b0;
      for (int n = 0; n < 300 && !seen; n++) begin
         @(negedge clk);
         if (a_done) seen = 1'b1;
      end
      vectors++;
      if (!seen || acc_a != 64 || q_a.size() != 0) begin
         miscompares++;
         $display("FAIL stall_total: got done=%0b accepted=%0d pending=%0d, required 1/64/0",
                  seen, acc_a, q_a.size());
      end
      bad_addr = 0;
      for (int i = 0; i < 128; i++) if (mem_a[i] != 0 || clr_a[i] != 1) bad_addr++;
      vectors++;
      if (bad_addr != 0) begin
         miscompares++;
         $display("FAIL stall_clear: %0d words wrong, required 0", bad_addr);
      end
   endtask

   task automatic test_round_noclear;
      logic [15:0] lo, hi;
      logic [12:0] r, t;
      exp_t e;
      bit seen;
      int bad;
      q_b.delete();
      acc_b = 0;
      for (int i = 0; i < 64; i++) begin
         lo = 16'($urandom);
         hi = 16'($urandom);
         if (i == 0) begin lo = 16'd12; hi = 16'd0; end
         if (i == 1) begin lo = 16'd0;  hi = 16'd1; end
         if (i == 2) begin lo = 16'd4;  hi = 16'd0; end
         mem_b[i] <= lo;  mem_b[i + 64] <= hi;
         save_b[i] = lo;  save_b[i + 64] = hi;
         clr_b[i] <= 0;   clr_b[i + 64] <= 0;
         r = lo[12:0] - hi[12:0];
         t = r + 13'd4;
         e.d   = {3'b000, t[12:3]};
         e.idx = 6'(i);
         q_b.push_back(e);
      end
      vectors++;
      if (q_b[0].d != 13'd2 || q_b[1].d != 13'd0 || q_b[2].d != 13'd1) begin
         miscompares++;
         $display("FAIL round_model: got %0d %0d %0d, required 2 0 1",
                  q_b[0].d, q_b[1].d, q_b[2].d);
      end
      b_ready = 1'b1;
      @(negedge clk);
      b_start = 1'b1;
      @(negedge clk);
      b_start = 1'b0;
      seen = 1'b0;
      for (int n = 0; n < 400 && !seen; n++) begin
         @(negedge clk);
         if (b_done) seen = 1'b1;
      end
      vectors++;
      if (!seen || acc_b != 64 || q_b.size() != 0) begin
         miscompares++;
         $display("FAIL round_stream: got done=%0b accepted=%0d pending=%0d, required 1/64/0",
                  seen, acc_b, q_b.size());
      end
      bad = 0;
      for (int i = 0; i < 128; i++) if (mem_b[i] != save_b[i] || clr_b[i] != 0) bad++;
      vectors++;
      if (bad != 0) begin
         miscompares++;
         $display("FAIL noclear: %0d words touched, required 0", bad);
      end
   endtask

   task automatic test_reset_midsweep;
      int k, dc;
      bit ok, reached;
      fill_a(1'b0);
      a_ready = 1'b1;
      kick_a(k);
      reached = 1'b0;
      for (int n = 0; n < 200 && !reached; n++) begin
         @(posedge clk);
         #1;
         if (acc_a >= 21) reached = 1'b1;
      end
      resetn = 1'b0;
      #1;
      vectors++;
      if (!reached ||
          {a_addr, a_clres, a_busy, a_valid, a_data, a_index, a_last, a_done} !== '0) begin
         miscompares++;
         $display("FAIL async_reset: reached=%0b outputs=%h, required 1/0", reached,
                  {a_addr, a_clres, a_busy, a_valid, a_data, a_index, a_last, a_done});
      end
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      fill_a(1'b0);
      kick_a(k);
      repeat (5) @(negedge clk);
      a_start = 1'b1;
      @(negedge clk);
      a_start = 1'b0;
      wait_done_a(dc, ok);
      vectors++;
      if (!ok || dc != k + 129 || acc_a != 64 || q_a.size() != 0) begin
         miscompares++;
         $display("FAIL restart: done=%0b cycle=%0d accepted=%0d pending=%0d, required 1/%0d/64/0",
                  ok, dc, acc_a, q_a.size(), k + 129);
      end
   endtask

   initial begin
      test_reset();
      test_timing();
      test_arith_random_ready();
      test_backpressure();
      test_round_noclear();
      test_reset_midsweep();
      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

endmodule
